// File: rtl/diaosi_types_pkg.sv
// Shared types for the pipeline sequencing controller.
package diaosi_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } pctl_state_t;

  localparam int unsigned PCTL_REG_W = 5;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the instruction in ID.
module hazard_detect
  import diaosi_types_pkg::*;
#(
  parameter int unsigned REG_W = PCTL_REG_W
) (
  input  logic             ex_dren,
  input  logic             ex_wen,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             load_use
);

  logic dst_live;
  logic rs_match;
  logic rt_match;

  // Register 0 is hardwired, so a load targeting it can never create a hazard.
  assign dst_live = ex_dren & ex_wen & (ex_wsel != '0);
  assign rs_match = (ex_wsel == id_rs);
  assign rt_match = id_uses_rt & (ex_wsel == id_rt);
  assign load_use = dst_live & (rs_match | rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline latch/PC sequencing controller with memory-wait and halted states.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_ctrl
  import diaosi_types_pkg::*;
#(
  parameter int unsigned REG_W = PCTL_REG_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dren,
  input  logic             mem_dwen,
  input  logic             mem_redirect,
  input  logic             mem_halt,
  input  logic             ex_dren,
  input  logic             ex_wen,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             halt
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]      cyc_cnt,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
`endif
);

  pctl_state_t state_reg;
  pctl_state_t state_next;
  logic        halt_reg;
  logic        load_use;
  logic        mem_ready;
  logic        active;
  logic        halt_accept;
  logic        redirect_accept;

  logic pc_en_dec;
  logic ifid_en_dec;
  logic ifid_flush_dec;
  logic idex_en_dec;
  logic idex_flush_dec;
  logic exmem_en_dec;
  logic exmem_flush_dec;
  logic memwb_en_dec;

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard_detect (
    .ex_dren    (ex_dren),
    .ex_wen     (ex_wen),
    .ex_wsel    (ex_wsel),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .load_use   (load_use)
  );

  assign mem_ready       = !(mem_dren | mem_dwen) | dhit;
  assign active          = (state_reg != HALTED);
  assign halt_accept     = active & mem_ready & mem_halt;
  assign redirect_accept = active & mem_ready & !mem_halt & mem_redirect;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= RUN;
      halt_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (halt_accept) begin
        halt_reg <= 1'b1;
      end
    end
  end

  // RUN and DWAIT share the same priority chain; DWAIT only differs in how it was entered.
  always_comb begin
    state_next      = state_reg;
    pc_en_dec       = 1'b0;
    ifid_en_dec     = 1'b0;
    ifid_flush_dec  = 1'b0;
    idex_en_dec     = 1'b0;
    idex_flush_dec  = 1'b0;
    exmem_en_dec    = 1'b0;
    exmem_flush_dec = 1'b0;
    memwb_en_dec    = 1'b0;
    case (state_reg)
      RUN, DWAIT: begin
        if (!mem_ready) begin
          state_next = DWAIT;
        end else if (mem_halt) begin
          state_next      = HALTED;
          exmem_en_dec    = 1'b1;
          exmem_flush_dec = 1'b1;
          memwb_en_dec    = 1'b1;
        end else if (mem_redirect) begin
          state_next      = RUN;
          pc_en_dec       = 1'b1;
          ifid_en_dec     = 1'b1;
          ifid_flush_dec  = 1'b1;
          idex_en_dec     = 1'b1;
          idex_flush_dec  = 1'b1;
          exmem_en_dec    = 1'b1;
          exmem_flush_dec = 1'b1;
          memwb_en_dec    = 1'b1;
        end else if (load_use) begin
          // IF/ID simply holds; a pending fetch miss is retried next cycle.
          state_next     = RUN;
          idex_en_dec    = 1'b1;
          idex_flush_dec = 1'b1;
          exmem_en_dec   = 1'b1;
          memwb_en_dec   = 1'b1;
        end else if (!ihit) begin
          state_next     = RUN;
          ifid_en_dec    = 1'b1;
          ifid_flush_dec = 1'b1;
          idex_en_dec    = 1'b1;
          exmem_en_dec   = 1'b1;
          memwb_en_dec   = 1'b1;
        end else begin
          state_next   = RUN;
          pc_en_dec    = 1'b1;
          ifid_en_dec  = 1'b1;
          idex_en_dec  = 1'b1;
          exmem_en_dec = 1'b1;
          memwb_en_dec = 1'b1;
        end
      end
      default: begin
        state_next = HALTED;
      end
    endcase
  end

  // Latches must not move while reset is held, even though the decode is combinational.
  assign pc_en       = pc_en_dec       & nRST;
  assign ifid_en     = ifid_en_dec     & nRST;
  assign ifid_flush  = ifid_flush_dec  & nRST;
  assign idex_en     = idex_en_dec     & nRST;
  assign idex_flush  = idex_flush_dec  & nRST;
  assign exmem_en    = exmem_en_dec    & nRST;
  assign exmem_flush = exmem_flush_dec & nRST;
  assign memwb_en    = memwb_en_dec    & nRST;
  assign halt        = halt_reg;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cyc_cnt_reg;
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cyc_cnt_reg   <= '0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else if (active) begin
      cyc_cnt_reg <= cyc_cnt_reg + 32'd1;
      if (!pc_en_dec) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (redirect_accept) begin
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
      end
    end
  end

  assign cyc_cnt   = cyc_cnt_reg;
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`else
  logic unused_redirect_accept;
  assign unused_redirect_accept = redirect_accept;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl; counter checks are built when PIPE_PERF_CNT_EN is defined.
module tb_pipeline_ctrl;
  import diaosi_types_pkg::*;

  localparam int unsigned REG_W = 5;

  // Control bundle order: pc, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en
  localparam logic [7:0] C_ALL   = 8'b1101_0101;
  localparam logic [7:0] C_NONE  = 8'b0000_0000;
  localparam logic [7:0] C_LU    = 8'b0001_1101;
  localparam logic [7:0] C_IMISS = 8'b0111_0101;
  localparam logic [7:0] C_REDIR = 8'b1111_1111;
  localparam logic [7:0] C_HALT  = 8'b0000_0111;

  logic             CLK;
  logic             nRST;
  logic             ihit, dhit, mem_dren, mem_dwen, mem_redirect, mem_halt;
  logic             ex_dren, ex_wen, id_uses_rt;
  logic [REG_W-1:0] ex_wsel, id_rs, id_rt;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic             exmem_en, exmem_flush, memwb_en, halt;
  logic [7:0]       ctrl;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]      cyc_cnt, stall_cnt, flush_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  assign ctrl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en};

  pipeline_ctrl #(.REG_W(REG_W)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ihit         (ihit),
    .dhit         (dhit),
    .mem_dren     (mem_dren),
    .mem_dwen     (mem_dwen),
    .mem_redirect (mem_redirect),
    .mem_halt     (mem_halt),
    .ex_dren      (ex_dren),
    .ex_wen       (ex_wen),
    .ex_wsel      (ex_wsel),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_en      (idex_en),
    .idex_flush   (idex_flush),
    .exmem_en     (exmem_en),
    .exmem_flush  (exmem_flush),
    .memwb_en     (memwb_en),
    .halt         (halt)
`ifdef PIPE_PERF_CNT_EN
    ,
    .cyc_cnt      (cyc_cnt),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %-14s got=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %-14s value=%0h (t=%0t)", tag, obs, $time);
    end
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; mem_dren = 1'b0; mem_dwen = 1'b0;
    mem_redirect = 1'b0; mem_halt = 1'b0;
    ex_dren = 1'b0; ex_wen = 1'b0; ex_wsel = '0;
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_use_inputs();
    ex_dren = 1'b1; ex_wen = 1'b1; ex_wsel = 5'd5; id_rs = 5'd5;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #1;
    check("rst_ctrl", 32'(ctrl), 32'(C_NONE));
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_state", 32'(dut.state_reg), 32'(RUN));
    @(negedge CLK);
    nRST = 1'b1;
    #1;
  endtask

  initial begin
    idle();
    do_reset();
    check("idle_run", 32'(ctrl), 32'(C_ALL));
    tick();

    // Load-use on rs: one bubble, then normal flow once the bubble reaches EX.
    load_use_inputs(); #1;
    check("lu_rs", 32'(ctrl), 32'(C_LU));
    tick(); idle(); #1;
    check("lu_after", 32'(ctrl), 32'(C_ALL));
    tick();

    // Load to r0 never stalls.
    ex_dren = 1'b1; ex_wen = 1'b1; ex_wsel = '0; id_rs = '0; #1;
    check("lu_r0", 32'(ctrl), 32'(C_ALL));
    tick(); idle();

    // rt match only counts when rt is actually read.
    ex_dren = 1'b1; ex_wen = 1'b1; ex_wsel = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b1; #1;
    check("lu_rt", 32'(ctrl), 32'(C_LU));
    id_uses_rt = 1'b0; #1;
    check("lu_rt_unused", 32'(ctrl), 32'(C_ALL));
    ex_wen = 1'b0; id_uses_rt = 1'b1; #1;
    check("lu_no_wen", 32'(ctrl), 32'(C_ALL));
    tick(); idle();

    // Fetch miss inserts a bubble in IF/ID.
    ihit = 1'b0; #1;
    check("imiss", 32'(ctrl), 32'(C_IMISS));
    load_use_inputs(); #1;
    check("lu_over_imiss", 32'(ctrl), 32'(C_LU));
    tick(); idle();

    // Data miss for three cycles, then completion.
    mem_dren = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("dwait_ctrl", 32'(ctrl), 32'(C_NONE));
      tick();
      check("dwait_state", 32'(dut.state_reg), 32'(DWAIT));
    end
    dhit = 1'b1; #1;
    check("dhit_ctrl", 32'(ctrl), 32'(C_ALL));
    tick(); idle(); #1;
    check("dhit_state", 32'(dut.state_reg), 32'(RUN));

    // A pending store blocks even a redirect.
    mem_dwen = 1'b1; mem_redirect = 1'b1; #1;
    check("redir_blocked", 32'(ctrl), 32'(C_NONE));
    dhit = 1'b1; ihit = 1'b0; #1;
    check("redir_imiss", 32'(ctrl), 32'(C_REDIR));
    tick(); idle(); #1;
    check("redir_state", 32'(dut.state_reg), 32'(RUN));

    // Halt retirement beats a simultaneous redirect.
    mem_halt = 1'b1; mem_redirect = 1'b1; #1;
    check("halt_ctrl", 32'(ctrl), 32'(C_HALT));
    check("halt_pre", 32'(halt), 32'd0);
    tick(); idle(); #1;
    check("halt_set", 32'(halt), 32'd1);
    check("halted_ctrl", 32'(ctrl), 32'(C_NONE));
    mem_redirect = 1'b1; tick(); #1;
    check("halt_sticky", 32'(halt), 32'd1);
    check("halted_hold", 32'(ctrl), 32'(C_NONE));
    idle();
    do_reset();
    check("post_rst_run", 32'(ctrl), 32'(C_ALL));

`ifdef PIPE_PERF_CNT_EN
    check("cyc_rst", cyc_cnt, 32'd0);
    // Ten cycles: load-use at 2 and 5, redirect at 7.
    for (int c = 1; c <= 10; c++) begin
      idle();
      if (c == 2 || c == 5) load_use_inputs();
      if (c == 7) mem_redirect = 1'b1;
      tick();
    end
    idle(); #1;
    check("cyc_cnt", cyc_cnt, 32'd10);
    check("stall_cnt", stall_cnt, 32'd2);
    check("flush_cnt", flush_cnt, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete within 20000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencing controller for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Each cycle it decides which latch advances, which latch takes a bubble, and when the PC may update. The decision draws on instruction/data memory handshakes, load-use hazards, control-flow redirects resolved in MEM, and halt retirement. It drives the enable and flush inputs of every stage latch and the PC enable, and holds a small FSM for memory wait and halted states.

## Interface
Parameters:
- REG_W, 5, register-select width (matches regbits_t)

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- ihit  in  1  instruction fetch for current PC completes this cycle
- dhit  in  1  data access of instruction in MEM completes this cycle
- mem_dren  in  1  instruction in MEM reads data memory
- mem_dwen  in  1  instruction in MEM writes data memory
- mem_redirect  in  1  instruction in MEM is a taken branch, jump or jr
- mem_halt  in  1  instruction in MEM is halt
- ex_dren  in  1  instruction in EX is a load
- ex_wen  in  1  instruction in EX writes the register file
- ex_wsel  in  REG_W  destination of instruction in EX
- id_rs, id_rt  in  REG_W each  source selects of instruction in ID
- id_uses_rt  in  1  instruction in ID reads rt
- pc_en  out  1  PC register loads next PC
- ifid_en, ifid_flush  out  1 each  IF/ID latch advance / load bubble
- idex_en, idex_flush  out  1 each  ID/EX latch advance / load bubble
- exmem_en, exmem_flush  out  1 each  EX/MEM latch advance / load bubble
- memwb_en  out  1  MEM/WB latch advance
- halt  out  1  processor halted, sticky

## Operation
- State enum pctl_state_t: RUN, DWAIT, HALTED. Reset state RUN.
- mem_ready = !(mem_dren|mem_dwen) | dhit.
- load_use = ex_dren & ex_wen & (ex_wsel != 0) & ((ex_wsel == id_rs) | (id_uses_rt & ex_wsel == id_rt)).
- Flush asserted only together with the same latch's enable. A flushed latch loads an all-zero bubble.
- Rules in RUN/DWAIT, highest priority first:
  - !mem_ready: all enables 0, flushes 0. Next state DWAIT.
  - mem_halt: memwb_en=1, exmem_en=1 with exmem_flush=1, pc_en/ifid_en/idex_en=0. Next state HALTED.
  - mem_redirect: pc_en=1 (target), ifid/idex/exmem all en=1 with flush=1, memwb_en=1. Next state RUN.
  - load_use: pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1, exmem_en=1, memwb_en=1.
  - !ihit: pc_en=0, ifid_en=1 with ifid_flush=1, idex/exmem/memwb en=1.
  - Otherwise all enables 1, flushes 0.
- DWAIT: leaves to RUN in the cycle dhit arrives. That cycle's outputs follow the RUN rules with mem_ready=1.
- HALTED: all enables and flushes 0, halt=1. Exits only by reset.
- load_use together with !ihit: load_use rule wins; IF/ID holds, with no bubble inserted.

## Timing
- All outputs are combinational from state and inputs, except halt, which is registered.
- Every decision takes effect at the rising edge ending the cycle.
- While nRST=0: state RUN, halt=0, all enables and flushes forced 0. Counters clear.
- halt rises one cycle after the cycle in which mem_halt & mem_ready was sampled.
- Load-use stall lasts exactly one cycle when ihit=1 and mem_ready=1.
- Reset asserted mid-DWAIT or mid-HALTED returns to RUN immediately (asynchronous).

## Configuration
- PIPE_PERF_CNT_EN defined adds three 32-bit outputs: cyc_cnt, stall_cnt, flush_cnt.
  - cyc_cnt increments every non-HALTED cycle.
  - stall_cnt increments when pc_en=0 outside HALTED.
  - flush_cnt increments on each mem_redirect acceptance.
  - All three wrap modulo 2^32 and clear on reset.
- PIPE_PERF_CNT_EN undefined: the ports and counters are absent. Control behaviour is identical.

## Structure
- pctl_state_t belongs in diaosi_types_pkg.
- One sub-module: hazard_detect, the combinational load_use compare, instantiated once.
- All priority logic and the FSM stay in pipeline_ctrl.

## Test plan
- Load-use: ex_dren=1, ex_wen=1, ex_wsel=5, id_rs=5, ihit=1 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables 1.
- ex_wsel=0 with id_rs=0, load in EX -> no stall, all enables 1.
- mem_dren=1, dhit=0 for 3 cycles, then dhit=1 -> enables 0 for 3 cycles with state DWAIT; 4th cycle all enables 1, state RUN.
- mem_redirect=1 with ihit=0 -> pc_en=1; ifid/idex/exmem flush=1; memwb_en=1.
- mem_halt=1, mem_ready=1 -> that cycle memwb_en=1, exmem_flush=1; halt=1 next cycle and thereafter; pulse nRST low -> halt=0, state RUN.
- With PIPE_PERF_CNT_EN: 10 cycles containing 2 load-use stalls and 1 redirect -> cyc_cnt=10, stall_cnt=2, flush_cnt=1.
